pulsador_antirrebote: RTL and testbench

Front-end conditioning stage for the pedestrian push-button of the traffic-light controller. It synchronises the raw, bouncing button input to `clk` and debounces it. It turns a press into a request level on `pulsador`, which the traffic-light FSM consumes and releases with a one-cycle `ack`. After each acknowledged request, a lockout window suppresses new requests and counts the presses it discards.

---
 rtl/pulsador_antirrebote.sv | 116 +++++++++++
 tb/tb_pulsador_antirrebote.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulsador_antirrebote.sv
// rtl/pulsador_antirrebote.sv - pedestrian button synchroniser, debouncer and request/lockout FSM
module pulsador_antirrebote #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       boton_in,
  input  logic       ack,
  output logic       pulsador,
  output logic       estable,
  output logic       pulso,
  output logic [3:0] descartes
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    LOCK = 2'd2
  } state_t;

  logic          boton_m;
  logic          boton_s;
  logic [DW-1:0] db_cnt;
  logic          db_done;
  logic [LW-1:0] lock_cnt;
  state_t        state;
  state_t        state_next;
  logic          pulsador_next;

  // Two-flop synchroniser bringing the raw button into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boton_m <= 1'b0;
      boton_s <= 1'b0;
    end else begin
      boton_m <= boton_in;
      boton_s <= boton_m;
    end
  end

  // The synchronised level has disagreed long enough to be accepted this edge
  assign db_done = (boton_s != estable) && (db_cnt == DB_LAST);

  // Debounce: any agreement with the current level restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt  <= '0;
      estable <= 1'b0;
      pulso   <= 1'b0;
    end else begin
      pulso <= db_done & boton_s;
      if (boton_s == estable) begin
        db_cnt <= '0;
      end else if (db_done) begin
        db_cnt  <= '0;
        estable <= boton_s;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // State register, with the request output registered alongside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pulsador <= 1'b0;
    end else begin
      state    <= state_next;
      pulsador <= pulsador_next;
    end
  end

  // Next-state logic; ack outside PEND is ignored and a pulso in PEND merges
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pulso) state_next = PEND;
      PEND:    if (ack) state_next = LOCK;
      LOCK:    if (lock_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: the request is held exactly while the FSM sits in PEND
  always_comb begin
    pulsador_next = (state_next == PEND);
  end

  // Lockout timer: loaded on the accepting ack, counts down to the IDLE exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
    end else if (state == PEND && ack) begin
      lock_cnt <= LOCK_LOAD;
    end else if (state == LOCK && lock_cnt != '0) begin
      lock_cnt <= lock_cnt - 1'b1;
    end
  end

  // Saturating tally of presses swallowed by the lockout window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      descartes <= 4'd0;
    end else if (state == LOCK && pulso && descartes != 4'hF) begin
      descartes <= descartes + 4'd1;
    end
  end

endmodule

// File: tb/tb_pulsador_antirrebote.sv
// tb/tb_pulsador_antirrebote.sv - self-checking bench for pulsador_antirrebote
module tb_pulsador_antirrebote;

  localparam int DB = 16;
  localparam int LK = 64;

  logic       clk;
  logic       rst;
  logic       boton_in;
  logic       ack;
  logic       pulsador;
  logic       estable;
  logic       pulso;
  logic [3:0] descartes;

  logic       rst2;
  logic       boton2;
  logic       ack2;
  logic       pulsador2;
  logic       estable2;
  logic       pulso2;
  logic [3:0] descartes2;

  int checks;
  int failures;
  int pulso_seen;

  pulsador_antirrebote #(.DEBOUNCE_CYCLES(DB), .LOCKOUT_CYCLES(LK)) dut (
    .clk(clk), .rst(rst), .boton_in(boton_in), .ack(ack),
    .pulsador(pulsador), .estable(estable), .pulso(pulso), .descartes(descartes)
  );

  pulsador_antirrebote #(.DEBOUNCE_CYCLES(DB), .LOCKOUT_CYCLES(1000)) dut_long (
    .clk(clk), .rst(rst2), .boton_in(boton2), .ack(ack2),
    .pulsador(pulsador2), .estable(estable2), .pulso(pulso2), .descartes(descartes2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: delay line, run length of disagreement, timestamped lockout
  int     m_dl [0:1];
  int     m_est;
  int     m_run;
  int     m_pulso;
  int     m_req;
  int     m_desc;
  longint m_edge;
  longint m_lock_end;

  task automatic model_reset();
    m_dl[0] = 0; m_dl[1] = 0;
    m_est = 0; m_run = 0; m_pulso = 0; m_req = 0; m_desc = 0;
    m_lock_end = -1;
  endtask

  task automatic model_edge(input int b, input int a, input int r);
    int old_s, old_est, old_p;
    m_edge++;
    if (r != 0) begin
      model_reset();
      return;
    end
    old_s = m_dl[1];
    old_est = m_est;
    old_p = m_pulso;
    if (m_req != 0) begin
      if (a != 0) begin
        m_req = 0;
        m_lock_end = m_edge + LK;
      end
    end else if (m_edge <= m_lock_end) begin
      if (old_p != 0 && m_desc < 15) m_desc++;
    end else if (old_p != 0) begin
      m_req = 1;
    end
    m_pulso = 0;
    if (old_s != old_est) begin
      m_run++;
      if (m_run == DB) begin
        m_est = old_s;
        m_run = 0;
        m_pulso = old_s;
      end
    end else begin
      m_run = 0;
    end
    m_dl[1] = m_dl[0];
    m_dl[0] = b;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at edge %0d: actual=%0d required=%0d", name, m_edge, act, exp);
    end
  endtask

  task automatic step(input logic b, input logic a, input logic r);
    boton_in = b;
    ack = a;
    rst = r;
    @(posedge clk);
    model_edge(int'(b), int'(a), int'(r));
    #1;
    if (pulso) pulso_seen++;
    chk("model.estable", int'(estable), m_est);
    chk("model.pulso", int'(pulso), m_pulso);
    chk("model.pulsador", int'(pulsador), m_req);
    chk("model.descartes", int'(descartes), m_desc);
  endtask

  task automatic step2(input logic b, input logic a, input logic r);
    boton2 = b;
    ack2 = a;
    rst2 = r;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic b;
    logic a;
    int   n;
    logic est;
    logic pls;
    logic pul;
    int   desc;
  } vec_t;

  function automatic vec_t mk(logic b, logic a, int n, logic est, logic pls, logic pul, int desc);
    vec_t v;
    v.b = b; v.a = a; v.n = n; v.est = est; v.pls = pls; v.pul = pul; v.desc = desc;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic cur_b;
    int   seg_left;
    checks = 0;
    failures = 0;
    pulso_seen = 0;
    m_edge = 0;
    model_reset();
    boton_in = 1'b0; ack = 1'b0; rst = 1'b1;
    boton2 = 1'b0; ack2 = 1'b0; rst2 = 1'b1;

    // clean press, handshake, lockout discards, ack in IDLE, ack with pulso in PEND
    tbl.push_back(mk(1, 0, 18, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0,  1, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 21, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 17, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0,  1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1,  1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 18, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0,  1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 18, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 19, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 30, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 19, 1, 0, 1, 2));
    tbl.push_back(mk(1, 1,  1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 70, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1,  3, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 19, 1, 0, 1, 2));
    tbl.push_back(mk(0, 0, 20, 0, 0, 1, 2));
    tbl.push_back(mk(1, 0, 18, 1, 1, 1, 2));
    tbl.push_back(mk(1, 1,  1, 1, 0, 0, 2));
    tbl.push_back(mk(1, 0,  2, 1, 0, 0, 2));

    // reset state
    step(0, 0, 1);
    chk("reset.pulsador", int'(pulsador), 0);
    chk("reset.estable", int'(estable), 0);
    chk("reset.descartes", int'(descartes), 0);
    step(0, 0, 0);

    // press to a pending request, then assert reset between edges
    for (int i = 0; i < 19; i++) step(1, 0, 0);
    chk("press.pulsador", int'(pulsador), 1);
    #5 rst = 1'b1;
    #1;
    chk("async_rst.pulsador", int'(pulsador), 0);
    chk("async_rst.estable", int'(estable), 0);
    model_reset();
    step(1, 0, 1);
    for (int i = 0; i < 18; i++) step(1, 0, 0);
    chk("rearm.pulso", int'(pulso), 1);
    step(1, 0, 0);
    chk("rearm.pulsador", int'(pulsador), 1);

    // table-driven scenario from a clean IDLE
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].b, tbl[i].a, 1'b0);
      chk($sformatf("tbl[%0d].estable", i), int'(estable), int'(tbl[i].est));
      chk($sformatf("tbl[%0d].pulso", i), int'(pulso), int'(tbl[i].pls));
      chk($sformatf("tbl[%0d].pulsador", i), int'(pulsador), int'(tbl[i].pul));
      chk($sformatf("tbl[%0d].descartes", i), int'(descartes), tbl[i].desc);
    end

    // bounce rejection: toggle every 5 cycles, then hold
    step(0, 0, 1);
    step(0, 0, 0);
    pulso_seen = 0;
    for (int s = 0; s < 12; s++)
      for (int k = 0; k < 5; k++) step(((s % 2) == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 17; k++) step(1, 0, 0);
    chk("bounce.no_pulso", pulso_seen, 0);
    step(1, 0, 0);
    chk("bounce.pulso", int'(pulso), 1);
    step(1, 0, 0);
    chk("bounce.single", int'(pulso), 0);
    chk("bounce.pulsador", int'(pulsador), 1);

    // randomized traffic against the model
    cur_b = 1'b0;
    seg_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (seg_left == 0) begin
        cur_b = 1'($urandom_range(0, 1));
        seg_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(15, 45));
      end
      seg_left--;
      step(cur_b, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 999) == 0));
    end
    step(0, 0, 0);

    // saturation with a long lockout
    step2(0, 0, 1);
    step2(0, 0, 0);
    for (int k = 0; k < 19; k++) step2(1, 0, 0);
    chk("long.pulsador", int'(pulsador2), 1);
    step2(1, 1, 0);
    chk("long.ack", int'(pulsador2), 0);
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < 20; k++) step2(0, 0, 0);
      for (int k = 0; k < 20; k++) step2(1, 0, 0);
      if (p == 2) chk("long.descartes3", int'(descartes2), 3);
    end
    chk("long.saturate", int'(descartes2), 15);
    chk("long.locked", int'(pulsador2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
